silife_host_ctrl: RTL and testbench
===================================

Name: silife_host_ctrl

Overview:
- Host-side initiator for the silife grid interface.
- Drives the grid's control byte (wr_en, en, row_select) and row-data byte, and samples the grid's row-output byte.
- Accepts simple commands: LOAD a full grid from a byte stream, RUN N generations, DUMP the full grid as a byte stream.
- Sits between a system-side controller (or an FPGA/RP2040 bridge) and the silife core, or in a bench as the protocol driver.

Parameters:
- ROWS, 32, number of grid rows; 1..32, since row_select is 5 bits.
- SETTLE, 1, cycles between changing row_select and sampling life_uo during DUMP; range 1..7.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=LOAD, 1=RUN, 2=DUMP, 3=reserved.
- cmd_count  in  16  generation count for RUN; ignored otherwise.
- load_data  in  8  row bits for LOAD, row 0 first.
- load_valid  in  1  load byte valid.
- load_ready  out  1  load byte accepted.
- dump_data  out  8  sampled row bits.
- dump_row  out  5  row index of dump_data.
- dump_valid  out  1  dump byte valid.
- dump_ready  in  1  dump consumer ready.
- busy  out  1  high in any state other than IDLE.
- life_ui  out  8  {wr_en, en, 1'b0, row_select[4:0]} to the core's dedicated inputs.
- life_uio  out  8  row data to the core's bidirectional inputs.
- life_uo  in  8  core's row output.

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 except cmd_ready=1; state=IDLE.
- Registered outputs: life_ui, life_uio, dump_* and load_ready are registered.
- Mutual exclusion: life_ui[7] (wr_en) and life_ui[6] (en) are never high in the same cycle. life_ui[5] is always 0.

States: IDLE, LOAD, RUN, DUMP_SEL, DUMP_WAIT, DUMP_OUT.

IDLE:
- cmd_valid&cmd_ready latches op/count.
- LOAD: go to LOAD, row counter r=0.
- RUN with count=0: stay IDLE, no en pulse.
- RUN with count>0: go to RUN.
- DUMP: go to DUMP_SEL, r=0.
- op=3: accepted, no effect.

LOAD:
- load_ready=1 while in LOAD.
- Each handshake registers, for exactly one cycle: wr_en=1, row_select=r, life_uio=load_data; then r++.
- Back-to-back handshakes give one row per cycle. Idle gaps drive wr_en=0.
- After the handshake with r=ROWS-1, go to IDLE; its wr_en pulse still occurs in the following cycle.
- life_uio holds its last value when wr_en=0.

RUN:
- en=1 for exactly cmd_count consecutive cycles, then 0, then go to IDLE.
- count=65535 is supported; no wrap.

DUMP:
- DUMP_SEL: drive row_select=r.
- DUMP_WAIT: wait SETTLE cycles.
- DUMP_OUT: capture life_uo into dump_data, dump_row=r; dump_valid=1.
- dump_data/dump_row stay stable until dump_ready. The handshake cycle drops dump_valid.
- Then r++ and go to DUMP_SEL; after r=ROWS-1, go to IDLE.
- A row is never re-sampled while dump_valid is high.

Boundaries:
- cmd_valid outside IDLE is ignored; cmd_ready=0.
- load_valid outside LOAD is ignored.
- rst_n low mid-operation: immediate return to reset values, including wr_en/en=0 asynchronously; partial transfers are discarded.

Optional Feature:
SILIFE_HOST_ABORT_EN
- Defined: adds input abort (1 bit). abort=1 in any non-IDLE state forces IDLE next cycle: wr_en=0, en=0, dump_valid=0, counters cleared. Remaining RUN generations and LOAD/DUMP rows are dropped. abort in IDLE has no effect.
- Undefined: no abort port; operations always run to completion.

Decomposition:
- Package silife_host_pkg:
  - op enum (OP_LOAD, OP_RUN, OP_DUMP, OP_RSVD).
  - state enum.
  - life_ui bit positions: UI_WR_EN=7, UI_EN=6, UI_ROW_LSB=0, UI_ROW_W=5.
  - MAX_ROWS=32.
- Single module; no sub-module. Counters (row, settle, generation) are inline.

Test Plan:
- LOAD of 32 bytes 0x00..0x1F, load_valid held high -> 32 consecutive cycles with wr_en=1, row_select=0..31, life_uio=0x00..0x1F; en=0 throughout; then busy=0.
- RUN count=5 -> en high exactly 5 consecutive cycles, wr_en=0; RUN count=0 -> en never rises, cmd_ready back high next cycle.
- Core model returns row^0xA5: DUMP with dump_ready toggling 1/0 -> 32 bytes (r^0xA5), dump_row=0..31 in order; data stable while dump_valid&!dump_ready.
- Blinker: LOAD row2=0x1C, others 0; RUN 1; DUMP -> rows 1,2,3 = 0x08, all others 0x00.
- Reset asserted at LOAD row 10 and at RUN cycle 3 of 100 -> outputs zero immediately; the next LOAD restarts at row 0.
- SILIFE_HOST_ABORT_EN: abort at RUN cycle 4 of 100 -> en low from next cycle, busy=0; abort during DUMP row 7 -> dump_valid drops, no rows 8..31 emitted.

Source files
------------

// File: rtl/silife_host_pkg.sv
// silife_host_pkg: shared types and life_ui field positions for the silife host controller.
// Imported by silife_host_ctrl.
package silife_host_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_RUN  = 2'd1,
        OP_DUMP = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DUMP_SEL,
        ST_DUMP_WAIT,
        ST_DUMP_OUT
    } state_e;

    localparam int UI_WR_EN   = 7;
    localparam int UI_EN      = 6;
    localparam int UI_ROW_LSB = 0;
    localparam int UI_ROW_W   = 5;
    localparam int MAX_ROWS   = 32;
    localparam int ROW_W      = $clog2(MAX_ROWS);

    function automatic logic [7:0] ui_word(
        input logic                wr,
        input logic                en,
        input logic [UI_ROW_W-1:0] row
    );
        logic [7:0] w;
        w = '0;
        w[UI_WR_EN] = wr;
        w[UI_EN] = en;
        w[UI_ROW_LSB +: UI_ROW_W] = row;
        return w;
    endfunction

endpackage

// File: rtl/silife_host_ctrl.sv
// silife_host_ctrl: LOAD / RUN / DUMP host initiator driving the silife grid pins.
// Optional abort input enabled by SILIFE_HOST_ABORT_EN.
module silife_host_ctrl
    import silife_host_pkg::*;
#(
    parameter int ROWS   = 32,
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SILIFE_HOST_ABORT_EN
    input  logic        abort,
`endif
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_count,
    input  logic [7:0]  load_data,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [7:0]  dump_data,
    output logic [4:0]  dump_row,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic        busy,
    output logic [7:0]  life_ui,
    output logic [7:0]  life_uio,
    input  logic [7:0]  life_uo
);

    localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(ROWS - 1);
    localparam logic [2:0]       LAST_SETTLE = 3'(SETTLE - 1);

    state_e           r_state;
    logic [ROW_W-1:0] r_row;
    logic [2:0]       r_settle;
    logic [15:0]      r_gen;
    logic [7:0]       r_ui;
    logic [7:0]       r_uio;
    logic [7:0]       r_dump_data;
    logic [4:0]       r_dump_row;
    logic             r_dump_valid;
    logic             r_load_ready;
    logic             r_cmd_ready;
    logic             r_busy;

    state_e           w_state_nxt;
    logic [ROW_W-1:0] w_row_nxt;
    logic [2:0]       w_settle_nxt;
    logic [15:0]      w_gen_nxt;
    logic [7:0]       w_ui_nxt;
    logic [7:0]       w_uio_nxt;
    logic [7:0]       w_dump_data_nxt;
    logic [4:0]       w_dump_row_nxt;
    logic             w_dump_valid_nxt;
    logic             w_wr_nxt;
    logic             w_en_nxt;
    logic [4:0]       w_sel_nxt;
    logic             w_cmd_hs;
    logic             w_load_hs;
    logic             w_dump_hs;
    logic             w_abort;

`ifdef SILIFE_HOST_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_cmd_hs  = cmd_valid & r_cmd_ready;
    assign w_load_hs = load_valid & r_load_ready;
    assign w_dump_hs = r_dump_valid & dump_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_settle_nxt     = r_settle;
        w_gen_nxt        = r_gen;
        w_uio_nxt        = r_uio;
        w_sel_nxt        = r_ui[UI_ROW_LSB +: UI_ROW_W];
        w_wr_nxt         = 1'b0;
        w_dump_data_nxt  = r_dump_data;
        w_dump_row_nxt   = r_dump_row;
        w_dump_valid_nxt = r_dump_valid;

        unique case (r_state)
            ST_IDLE: begin
                if (w_cmd_hs) begin
                    unique case (op_e'(cmd_op))
                        OP_LOAD: begin
                            w_state_nxt = ST_LOAD;
                            w_row_nxt   = '0;
                        end
                        OP_RUN: begin
                            if (cmd_count != 16'd0) begin
                                w_state_nxt = ST_RUN;
                                w_gen_nxt   = cmd_count;
                            end
                        end
                        OP_DUMP: begin
                            w_state_nxt = ST_DUMP_SEL;
                            w_row_nxt   = '0;
                        end
                        OP_RSVD: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (w_load_hs) begin
                    w_wr_nxt  = 1'b1;
                    w_sel_nxt = r_row;
                    w_uio_nxt = load_data;
                    w_row_nxt = r_row + 1'b1;
                    if (r_row == LAST_ROW) begin
                        w_state_nxt = ST_IDLE;
                        w_row_nxt   = '0;
                    end
                end
            end
            ST_RUN: begin
                // r_gen holds the generations still to be clocked, this one included
                w_gen_nxt = r_gen - 16'd1;
                if (r_gen == 16'd1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DUMP_SEL: begin
                w_sel_nxt    = r_row;
                w_settle_nxt = '0;
                w_state_nxt  = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                w_settle_nxt = r_settle + 3'd1;
                if (r_settle == LAST_SETTLE) begin
                    w_state_nxt      = ST_DUMP_OUT;
                    w_dump_data_nxt  = life_uo;
                    w_dump_row_nxt   = r_row;
                    w_dump_valid_nxt = 1'b1;
                end
            end
            ST_DUMP_OUT: begin
                if (w_dump_hs) begin
                    w_dump_valid_nxt = 1'b0;
                    w_row_nxt        = r_row + 1'b1;
                    w_state_nxt      = ST_DUMP_SEL;
                    if (r_row == LAST_ROW) begin
                        w_state_nxt = ST_IDLE;
                        w_row_nxt   = '0;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_abort && (r_state != ST_IDLE)) begin
            w_state_nxt      = ST_IDLE;
            w_row_nxt        = '0;
            w_settle_nxt     = '0;
            w_gen_nxt        = '0;
            w_wr_nxt         = 1'b0;
            w_dump_valid_nxt = 1'b0;
        end

        // en is a pure decode of the next state, so it can never overlap wr_en
        w_en_nxt = (w_state_nxt == ST_RUN);
        w_ui_nxt = ui_word(w_wr_nxt, w_en_nxt, w_sel_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_settle     <= '0;
            r_gen        <= '0;
            r_ui         <= '0;
            r_uio        <= '0;
            r_dump_data  <= '0;
            r_dump_row   <= '0;
            r_dump_valid <= 1'b0;
            r_load_ready <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_settle     <= w_settle_nxt;
            r_gen        <= w_gen_nxt;
            r_ui         <= w_ui_nxt;
            r_uio        <= w_uio_nxt;
            r_dump_data  <= w_dump_data_nxt;
            r_dump_row   <= w_dump_row_nxt;
            r_dump_valid <= w_dump_valid_nxt;
            r_load_ready <= (w_state_nxt == ST_LOAD);
            r_cmd_ready  <= (w_state_nxt == ST_IDLE);
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign load_ready = r_load_ready;
    assign busy       = r_busy;
    assign life_ui    = r_ui;
    assign life_uio   = r_uio;
    assign dump_data  = r_dump_data;
    assign dump_row   = r_dump_row;
    assign dump_valid = r_dump_valid;

endmodule

// File: tb/tb_silife_host_ctrl.sv
// tb_silife_host_ctrl: scoreboard bench for silife_host_ctrl with a small grid core model.
// Abort scenarios are built when SILIFE_HOST_ABORT_EN is defined.
module tb_silife_host_ctrl;
    import silife_host_pkg::*;

    typedef logic [7:0] grid_t [32];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  dump_data;
    logic [4:0]  dump_row;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic        busy;
    logic [7:0]  life_ui;
    logic [7:0]  life_uio;
    logic [7:0]  life_uo;
`ifdef SILIFE_HOST_ABORT_EN
    logic        abort = 1'b0;
`endif

    always #5 clk = ~clk;

    silife_host_ctrl #(.ROWS(32), .SETTLE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SILIFE_HOST_ABORT_EN
        .abort      (abort),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dump_data  (dump_data),
        .dump_row   (dump_row),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .busy       (busy),
        .life_ui    (life_ui),
        .life_uio   (life_uio),
        .life_uo    (life_uo)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // grid core model: writes on wr_en, one Life generation per en cycle
    grid_t grid = '{default: 8'h00};
    bit    xor_mode = 1'b0;

    function automatic grid_t life_step(input grid_t g);
        grid_t nx;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 32 &&
                            cc >= 0 && cc < 8) begin
                            if (g[5'(rr)][3'(cc)]) n++;
                        end
                    end
                end
                nx[5'(r)][3'(c)] = (n == 3) || (g[5'(r)][3'(c)] && n == 2);
            end
        end
        return nx;
    endfunction

    assign life_uo = xor_mode ? ({3'b000, life_ui[4:0]} ^ 8'hA5)
                              : grid[life_ui[4:0]];

    always @(posedge clk) begin
        if (life_ui[7]) grid[life_ui[4:0]] <= life_uio;
        else if (life_ui[6]) grid <= life_step(grid);
    end

    logic [12:0] q_wr[$];
    logic [12:0] q_dump[$];
    int          q_run[$];
    int          last_wr_len = 0;
    int          rdy_mode = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) dump_ready = ~dump_ready;
            else dump_ready = 1'b1;
        end
    end

    initial begin
        int          wr_len = 0;
        int          en_len = 0;
        bit          hold = 1'b0;
        logic [12:0] hold_v = '0;
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_len = 0;
                en_len = 0;
                hold = 1'b0;
            end else begin
                if (life_ui[7] || life_ui[6]) begin
                    check("wr_en_mutex", 32'(life_ui[7] & life_ui[6]), 0);
                    check("ui_bit5", 32'(life_ui[5]), 0);
                end
                if (life_ui[7]) begin
                    wr_len++;
                    if (q_wr.size() == 0) begin
                        check("wr_extra", 32'({life_ui[4:0], life_uio}), 32'h1FFF);
                    end else begin
                        e = q_wr.pop_front();
                        check("wr_row_data", 32'({life_ui[4:0], life_uio}), 32'(e));
                    end
                end else if (wr_len > 0) begin
                    last_wr_len = wr_len;
                    wr_len = 0;
                end
                if (life_ui[6]) begin
                    en_len++;
                end else if (en_len > 0) begin
                    if (q_run.size() == 0) check("run_extra", en_len, 0);
                    else check("run_len", en_len, q_run.pop_front());
                    en_len = 0;
                end
                if (hold) begin
                    check("dump_stable", 32'({dump_valid, dump_row, dump_data}),
                          32'({1'b1, hold_v}));
                end
                if (dump_valid && dump_ready) begin
                    if (q_dump.size() == 0) begin
                        check("dump_extra", 32'({dump_row, dump_data}), 32'h1FFF);
                    end else begin
                        e = q_dump.pop_front();
                        check("dump_row_data", 32'({dump_row, dump_data}), 32'(e));
                    end
                end
                hold = dump_valid && !dump_ready;
                hold_v = {dump_row, dump_data};
            end
        end
    end

    logic [7:0] ld_bytes [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        check({pfx, "_cmd_ready"}, 32'(cmd_ready), 1);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_life_ui"}, 32'(life_ui), 0);
        check({pfx, "_life_uio"}, 32'(life_uio), 0);
        check({pfx, "_load_ready"}, 32'(load_ready), 0);
        check({pfx, "_dump_valid"}, 32'(dump_valid), 0);
        check({pfx, "_dump_data"}, 32'({dump_row, dump_data}), 0);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [15:0] cnt);
        int t = 0;
        while (!cmd_ready && t < 300) begin
            tick();
            t++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_op = op;
        cmd_count = cnt;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int t = 0;
        while (busy && t < max) begin
            tick();
            t++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic do_load(input bit gaps, input int rst_at);
        do_cmd(OP_LOAD, 16'd0);
        for (int i = 0; i < 32; i++) begin
            int t = 0;
            if (gaps && (i % 3 == 2)) begin
                load_valid = 1'b0;
                tick();
            end
            load_data = ld_bytes[i];
            load_valid = 1'b1;
            while (!load_ready && t < 50) begin
                tick();
                t++;
            end
            if (t >= 50) check("load_ready_wait", 32'(load_ready), 1);
            q_wr.push_back({5'(i), ld_bytes[i]});
            tick();
            if (i == rst_at) begin
                rst_n = 1'b0;
                load_valid = 1'b0;
                q_wr.delete();
                #1;
                chk_reset_vals("rst_load");
                return;
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic do_dump(input int mode);
        rdy_mode = mode;
        do_cmd(OP_DUMP, 16'd0);
        wait_idle(2000);
        repeat (3) tick();
        check("dump_all_seen", q_dump.size(), 0);
        rdy_mode = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_count = '0;
        load_data = '0;
        load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) ld_bytes[i] = 8'(i);
        do_load(1'b0, -1);
        wait_idle(20);
        repeat (3) tick();
        check("load_consecutive", last_wr_len, 32);
        check("uio_hold", 32'(life_uio), 32'h1F);

        q_run.push_back(5);
        do_cmd(OP_RUN, 16'd5);
        wait_idle(50);
        repeat (2) tick();
        do_cmd(OP_RUN, 16'd0);
        check("run0_cmd_ready", 32'(cmd_ready), 1);
        check("run0_busy", 32'(busy), 0);
        do_cmd(OP_RSVD, 16'd7);
        check("rsvd_busy", 32'(busy), 0);
        repeat (5) tick();

        xor_mode = 1'b1;
        for (int r = 0; r < 32; r++) q_dump.push_back({5'(r), 8'(r) ^ 8'hA5});
        do_dump(1);
        xor_mode = 1'b0;

        for (int i = 0; i < 32; i++) ld_bytes[i] = 8'h00;
        ld_bytes[2] = 8'h1C;
        do_load(1'b1, -1);
        wait_idle(80);
        q_run.push_back(1);
        do_cmd(OP_RUN, 16'd1);
        wait_idle(20);
        repeat (2) tick();
        for (int r = 0; r < 32; r++) begin
            q_dump.push_back({5'(r), (r >= 1 && r <= 3) ? 8'h08 : 8'h00});
        end
        do_dump(0);

        for (int i = 0; i < 32; i++) ld_bytes[i] = 8'(i * 3 + 1);
        do_load(1'b0, 10);
        tick();
        rst_n = 1'b1;
        tick();

        do_cmd(OP_RUN, 16'd100);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_run");
        tick();
        rst_n = 1'b1;
        tick();

        do_load(1'b0, -1);
        wait_idle(20);
        load_data = 8'hEE;
        load_valid = 1'b1;
        repeat (4) tick();
        load_valid = 1'b0;
        check("idle_no_load_ready", 32'(load_ready), 0);

`ifdef SILIFE_HOST_ABORT_EN
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_busy", 32'(busy), 0);
        check("abort_idle_ready", 32'(cmd_ready), 1);

        q_run.push_back(4);
        do_cmd(OP_RUN, 16'd100);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_run_en", 32'(life_ui[6]), 0);
        check("abort_run_busy", 32'(busy), 0);
        repeat (3) tick();

        xor_mode = 1'b1;
        rdy_mode = 0;
        for (int r = 0; r < 8; r++) q_dump.push_back({5'(r), 8'(r) ^ 8'hA5});
        do_cmd(OP_DUMP, 16'd0);
        begin
            int t = 0;
            while (!(dump_valid && dump_row == 5'd7) && t < 500) begin
                tick();
                t++;
            end
            check("abort_dump_row7", 32'({dump_valid, dump_row}), 32'h27);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_dump_valid", 32'(dump_valid), 0);
        check("abort_dump_busy", 32'(busy), 0);
        repeat (100) tick();
        xor_mode = 1'b0;
`endif

        repeat (5) tick();
        check("q_wr_empty", q_wr.size(), 0);
        check("q_run_empty", q_run.size(), 0);
        check("q_dump_empty", q_dump.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
